quad_decoder: RTL and testbench

- Quadrature decoder: converts a two-phase incremental encoder signal pair (A/B) into step/direction events and a wrapping position count.
- Receiving end of the up/down counting interface. Replaces an external en/up pair with phase-decoded motion.
- Sits between asynchronous encoder pins and control logic. Provides synchronisation, glitch filtering, x4 decoding and illegal-transition detection.

---
 rtl/quad_decoder.sv | 126 ++++++++++++
 tb/tb_quad_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters encoder phases A/B,
// decodes x4 steps into a wrapping position count with step/dir/err flags.
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] position,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] FL = CW'(FILT_LEN);

    logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b;
    logic [1:0]             r_cand;
    logic [1:0]             r_filt;
    logic [CW-1:0]          r_cnt;
    logic                   r_init;
    logic                   r_evt_up, r_evt_dn, r_evt_err;
    logic [WIDTH-1:0]       r_position;
    logic                   r_step, r_dir, r_err;

    logic [1:0]    w_s;
    logic [CW-1:0] w_cnt_inc;
    logic [1:0]    w_idx_old, w_idx_new, w_diff;

    // Gray position of an {a,b} pair along the up sequence 00,10,11,01
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    assign w_s       = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    // Count includes the current sample, so a fresh level is sample #1
    assign w_cnt_inc = (w_s == r_cand) ? r_cnt + CW'(1) : CW'(1);
    assign w_idx_old = gray_idx(r_filt);
    assign w_idx_new = gray_idx(w_s);
    assign w_diff    = w_idx_new - w_idx_old;

    // Metastability chains for the asynchronous encoder pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], quad_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], quad_b};
        end
    end

    // Glitch filter and transition classification; first accepted level only seeds state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand    <= 2'b00;
            r_filt    <= 2'b00;
            r_cnt     <= '0;
            r_init    <= 1'b1;
            r_evt_up  <= 1'b0;
            r_evt_dn  <= 1'b0;
            r_evt_err <= 1'b0;
        end else begin
            r_cand    <= w_s;
            r_evt_up  <= 1'b0;
            r_evt_dn  <= 1'b0;
            r_evt_err <= 1'b0;
            if (w_s == r_filt) begin
                r_cnt <= '0;
            end else if (w_cnt_inc >= FL) begin
                r_cnt  <= '0;
                r_filt <= w_s;
                r_init <= 1'b0;
                if (!r_init) begin
                    r_evt_up  <= (w_diff == 2'd1);
                    r_evt_dn  <= (w_diff == 2'd3);
                    r_evt_err <= (w_diff == 2'd2);
                end
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Position/flags update one cycle after the filtered state moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_position <= '0;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (r_evt_err)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
            if (en && r_evt_up)
                r_dir <= 1'b1;
            else if (en && r_evt_dn)
                r_dir <= 1'b0;
            if (clear) begin
                r_position <= '0;
            end else if (en && r_evt_up) begin
                r_position <= r_position + WIDTH'(1);
                r_step     <= 1'b1;
            end else if (en && r_evt_dn) begin
                r_position <= r_position - WIDTH'(1);
                r_step     <= 1'b1;
            end
        end
    end

    assign position = r_position;
    assign step     = r_step;
    assign dir      = r_dir;
    assign err      = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (defaults WIDTH=8, SYNC_STAGES=2, FILT_LEN=3).
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst, en, clear, quad_a, quad_b, err_clr;
    logic [7:0] position;
    logic       step, dir, err;

    int n_chk = 0;
    int n_pass = 0;
    int n_steps = 0;
    int idx = 0;       // gray index of driven level: 0=00 1=10 2=11 3=01
    int s0;

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
        .position(position), .step(step), .dir(dir), .err(err)
    );

    always #5 clk = ~clk;

    // step is a full-cycle pulse, so one sample per negedge counts it once
    always @(negedge clk) if (step) n_steps++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive_idx();
        case (idx & 3)
            0: {quad_a, quad_b} = 2'b00;
            1: {quad_a, quad_b} = 2'b10;
            2: {quad_a, quad_b} = 2'b11;
            default: {quad_a, quad_b} = 2'b01;
        endcase
    endtask

    task automatic move(input int delta, input int hold);
        @(negedge clk);
        idx = (idx + delta) & 3;
        drive_idx();
        repeat (hold) @(negedge clk);
    endtask

    // Move and pulse err_clr (sel=1) or clear (sel=2) on the edge that applies the count
    task automatic move_pulse(input int delta, input int sel);
        @(negedge clk);
        idx = (idx + delta) & 3;
        drive_idx();
        repeat (5) @(negedge clk);
        if (sel == 1) err_clr = 1'b1; else clear = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        clear   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; err_clr = 1'b0;
        quad_a = 1'b0; quad_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", position, 0);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First accepted level after reset only seeds state
        move(1, 10);
        chk("init_pos", position, 0);
        s0 = n_steps;
        for (int i = 0; i < 32; i++) move(1, 10);
        chk("up32_pos", position, 32);
        chk("up32_steps", n_steps - s0, 32);
        chk("up32_dir", dir, 1);
        chk("up32_err", err, 0);

        // Walk up to 255, then wrap both ways
        for (int i = 0; i < 223; i++) move(1, 8);
        chk("pre255_pos", position, 255);
        move(1, 8);
        chk("wrap_up_pos", position, 0);
        move(-1, 8);
        chk("wrap_dn_pos", position, 255);
        chk("wrap_dn_dir", dir, 0);

        // 2-cycle glitch on A is rejected
        s0 = n_steps;
        @(negedge clk); quad_a = ~quad_a;
        repeat (2) @(negedge clk); quad_a = ~quad_a;
        repeat (10) @(negedge clk);
        chk("glitch_pos", position, 255);
        chk("glitch_steps", n_steps - s0, 0);
        // 3-cycle pulse is accepted: one step out, one step back
        @(negedge clk); quad_a = ~quad_a;
        repeat (3) @(negedge clk); quad_a = ~quad_a;
        repeat (12) @(negedge clk);
        chk("pulse3_pos", position, 255);
        chk("pulse3_steps", n_steps - s0, 2);
        chk("pulse3_err", err, 0);

        // Illegal double-phase jump
        s0 = n_steps;
        move(2, 8);
        chk("illegal_err", err, 1);
        chk("illegal_pos", position, 255);
        chk("illegal_steps", n_steps - s0, 0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errclr_err", err, 0);
        move_pulse(2, 1);
        chk("set_wins_err", err, 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errclr2_err", err, 0);

        // en=0: levels tracked, counts discarded
        en = 1'b0;
        s0 = n_steps;
        for (int i = 0; i < 4; i++) move(1, 8);
        chk("en0_pos", position, 255);
        chk("en0_steps", n_steps - s0, 0);
        en = 1'b1;
        move(1, 8);
        chk("reen_pos", position, 0);
        chk("reen_steps", n_steps - s0, 1);
        move(1, 8);
        chk("pre_clr_pos", position, 1);
        s0 = n_steps;
        move_pulse(1, 2);
        chk("clr_pos", position, 0);
        chk("clr_steps", n_steps - s0, 0);

        // Encoder resting at 11 across reset
        @(negedge clk);
        idx = 2; drive_idx();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = n_steps;
        repeat (10) @(negedge clk);
        chk("reacq_pos", position, 0);
        chk("reacq_err", err, 0);
        chk("reacq_steps", n_steps - s0, 0);
        move(1, 8);
        chk("reacq_up_pos", position, 1);
        chk("reacq_up_dir", dir, 1);
        chk("reacq_up_steps", n_steps - s0, 1);

        // Asynchronous reset away from any clock edge
        move(1, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_pos", position, 0);
        chk("arst_dir", dir, 0);
        chk("arst_step", step, 0);
        chk("arst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
